// File: rtl/pipeline_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// requester IDs, counter widths and a saturating-increment helper.
package pipeline_arb_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_RD_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_e;

  localparam int PERF_W   = 16;
  localparam int STARVE_W = 4;
  localparam int LAT_W    = 3;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter for the DMA requester; o_at_limit tells the
// arbiter that DMA has lost arbitration LIMIT consecutive times.
module arb_starve_ctr
  import pipeline_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

  logic [STARVE_W-1:0] r_cnt;

  // NOTE: sequential state is only ever assigned with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIMIT_V)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == LIMIT_V);

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for the single-port data memory: fixed CPU priority with a
// DMA starvation guard, one transaction outstanding. Define DMEM_ARB_PERF_EN
// to add the perf_cpu_stall / perf_dma_grants saturating counters.
module dmem_arbiter
  import pipeline_arb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_cpu_stall,
  output logic [PERF_W-1:0] perf_dma_grants
`endif
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LATENCY - 1);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  req_id_e           r_owner;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic              r_cpu_ack;
  logic              r_dma_ack;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic w_cpu_elig;
  logic w_dma_elig;
  logic w_at_limit;
  logic w_issue;
  logic w_grant_cpu;
  logic w_grant_dma;
  logic w_win_wr;
  logic w_rd_done;

  // A requester in its ack cycle is not eligible, so a held req cannot reissue.
  assign w_cpu_elig  = cpu_req & ~r_cpu_ack;
  assign w_dma_elig  = dma_req & ~r_dma_ack;
  assign w_issue     = reset & (r_state == ARB_IDLE) & (w_cpu_elig | w_dma_elig);
  assign w_grant_dma = w_issue & w_dma_elig & (~w_cpu_elig | w_at_limit);
  assign w_grant_cpu = w_issue & ~w_grant_dma;
  assign w_win_wr    = w_grant_dma ? dma_wr : cpu_wr;
  assign w_rd_done   = (r_state == ARB_RD_WAIT) && (r_lat_cnt == '0);

  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (w_issue & w_dma_elig & ~w_grant_dma),
    .i_clr     (w_grant_dma),
    .o_at_limit(w_at_limit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE:    if (w_issue && !w_win_wr) w_next_state = ARB_RD_WAIT;
      ARB_RD_WAIT: if (w_rd_done) w_next_state = ARB_IDLE;
      default:     w_next_state = ARB_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the branches, so no path through
  // this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    mem_en    = w_issue;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_grant_dma) begin
      mem_wr    = dma_wr;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (w_grant_cpu) begin
      mem_wr    = cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner     <= REQ_CPU;
      r_lat_cnt   <= '0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      if (w_issue) begin
        r_owner   <= w_grant_dma ? REQ_DMA : REQ_CPU;
        r_lat_cnt <= LAT_INIT;
        if (w_win_wr) begin
          r_cpu_ack <= w_grant_cpu;
          r_dma_ack <= w_grant_dma;
        end
      end
      if (r_state == ARB_RD_WAIT) begin
        if (w_rd_done) begin
          if (r_owner == REQ_DMA) begin
            r_dma_ack   <= 1'b1;
            r_dma_rdata <= mem_rdata;
          end else begin
            r_cpu_ack   <= 1'b1;
            r_cpu_rdata <= mem_rdata;
          end
        end else begin
          r_lat_cnt <= r_lat_cnt - 1'b1;
        end
      end
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign dma_ack   = r_dma_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;
  assign cpu_stall = cpu_req & ~r_cpu_ack;

`ifdef DMEM_ARB_PERF_EN
  logic [PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0] r_perf_dma;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_stall <= '0;
      r_perf_dma   <= '0;
    end else begin
      if (cpu_stall)   r_perf_stall <= sat_inc(r_perf_stall);
      if (w_grant_dma) r_perf_dma   <= sat_inc(r_perf_dma);
    end
  end

  assign perf_cpu_stall  = r_perf_stall;
  assign perf_dma_grants = r_perf_dma;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a cycle-level reference of the arbitration
// rules predicts every bus cycle and queues expected acks; a monitor checks them.
module tb_dmem_arbiter;

  localparam int RD_LAT = 2;
  localparam int SLIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0, dma_req = 1'b0, dma_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        cpu_ack, cpu_stall, dma_ack, mem_en, mem_wr;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perf_cpu_stall, perf_dma_grants;
  logic [15:0] exp_pstall = '0, exp_pdma = '0;
`endif

  dmem_arbiter #(
    .DATA_W(32), .ADDR_W(32), .RD_LATENCY(RD_LAT), .STARVE_LIMIT(SLIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_cpu_stall(perf_cpu_stall), .perf_dma_grants(perf_dma_grants)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          rd;
    logic [31:0] data;
  } ack_t;

  ack_t        cq[$], dq[$];
  logic [31:0] mem_ref[16], mem_dev[16];
  logic [31:0] exp_crd = '0, exp_drd = '0;
  int          cyc = 0, busy_until = 0, starve = 0;
  int          total = 0, bad = 0;
  bit          m_cack = 0, m_dack = 0;
  bit          rd_pend = 0;
  int          rd_due = 0;
  logic [3:0]  rd_idx = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: no ack within bound, expected one (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory device: responds to whatever the DUT actually puts on the bus.
  always @(negedge clk) begin
    if (!reset) begin
      rd_pend = 0;
    end else if (mem_en) begin
      if (mem_wr) mem_dev[mem_addr[5:2]] = mem_wdata;
      else begin
        rd_pend = 1;
        rd_due  = cyc + RD_LAT;
        rd_idx  = mem_addr[5:2];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rd_pend && cyc == rd_due) begin
      mem_rdata = mem_dev[rd_idx];
      rd_pend   = 0;
    end else begin
      mem_rdata = $urandom;
    end
  end

  // Reference model and monitor, evaluated once per cycle with inputs settled.
  always @(negedge clk) begin : model
    bit          ec, ed, cel, del, idle, gc, gd, e_wr;
    logic [31:0] e_addr, e_wdata;
    if (!reset) begin
      cq.delete();
      dq.delete();
      busy_until = 0;
      starve     = 0;
      exp_crd    = '0;
      exp_drd    = '0;
      m_cack     = 0;
      m_dack     = 0;
      check("rst_mem_en", 64'(mem_en), 64'(0));
      check("rst_mem_addr", 64'(mem_addr), 64'(0));
      check("rst_cpu_ack", 64'(cpu_ack), 64'(0));
      check("rst_dma_ack", 64'(dma_ack), 64'(0));
      check("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
      check("rst_dma_rdata", 64'(dma_rdata), 64'(0));
      check("rst_cpu_stall", 64'(cpu_stall), 64'(cpu_req));
`ifdef DMEM_ARB_PERF_EN
      exp_pstall = '0;
      exp_pdma   = '0;
      check("rst_perf_stall", 64'(perf_cpu_stall), 64'(0));
      check("rst_perf_dma", 64'(perf_dma_grants), 64'(0));
`endif
    end else begin
      ec   = (cq.size() > 0) && (cq[0].due == cyc);
      ed   = (dq.size() > 0) && (dq[0].due == cyc);
      cel  = cpu_req && !ec;
      del  = dma_req && !ed;
      idle = (cyc >= busy_until);
      gd   = idle && del && (!cel || starve == SLIMIT);
      gc   = idle && cel && !gd;
      e_wr    = gd ? dma_wr    : (gc ? cpu_wr    : 1'b0);
      e_addr  = gd ? dma_addr  : (gc ? cpu_addr  : 32'h0);
      e_wdata = gd ? dma_wdata : (gc ? cpu_wdata : 32'h0);

      check("mem_en", 64'(mem_en), 64'(gc || gd));
      check("mem_wr", 64'(mem_wr), 64'(e_wr));
      check("mem_addr", 64'(mem_addr), 64'(e_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
      check("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !ec));
      check("cpu_ack", 64'(cpu_ack), 64'(ec));
      check("dma_ack", 64'(dma_ack), 64'(ed));
`ifdef DMEM_ARB_PERF_EN
      check("perf_stall", 64'(perf_cpu_stall), 64'(exp_pstall));
      check("perf_dma", 64'(perf_dma_grants), 64'(exp_pdma));
      if (cpu_req && !ec && exp_pstall != 16'hFFFF) exp_pstall = exp_pstall + 1'b1;
      if (gd && exp_pdma != 16'hFFFF) exp_pdma = exp_pdma + 1'b1;
`endif

      if (ec) begin
        if (cq[0].rd) exp_crd = cq[0].data;
        void'(cq.pop_front());
      end
      if (ed) begin
        if (dq[0].rd) exp_drd = dq[0].data;
        void'(dq.pop_front());
      end
      check("cpu_rdata", 64'(cpu_rdata), 64'(exp_crd));
      check("dma_rdata", 64'(dma_rdata), 64'(exp_drd));

      if (idle && del) starve = gd ? 0 : ((starve < SLIMIT) ? starve + 1 : starve);

      if (gc) begin
        if (cpu_wr) begin
          mem_ref[cpu_addr[5:2]] = cpu_wdata;
          cq.push_back('{due: cyc + 1, rd: 1'b0, data: 32'h0});
        end else begin
          cq.push_back('{due: cyc + RD_LAT + 1, rd: 1'b1, data: mem_ref[cpu_addr[5:2]]});
          busy_until = cyc + RD_LAT + 1;
        end
      end
      if (gd) begin
        if (dma_wr) begin
          mem_ref[dma_addr[5:2]] = dma_wdata;
          dq.push_back('{due: cyc + 1, rd: 1'b0, data: 32'h0});
        end else begin
          dq.push_back('{due: cyc + RD_LAT + 1, rd: 1'b1, data: mem_ref[dma_addr[5:2]]});
          busy_until = cyc + RD_LAT + 1;
        end
      end
      m_cack = ec;
      m_dack = ed;
    end
  end

  task automatic wait_ack(input bit is_dma, input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!(is_dma ? m_dack : m_cack) && n < 100);
    if (!(is_dma ? m_dack : m_cack)) timeout_fail(tag);
  endtask

  // Called at posedge+1; returns at posedge+1 with the request dropped.
  task automatic cpu_txn(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    wait_ack(1'b0, "cpu_ack_wait");
    #1;
    cpu_req = 1'b0; cpu_wr = $urandom_range(0, 1); cpu_addr = $urandom; cpu_wdata = $urandom;
  endtask

  task automatic dma_txn(input logic wr, input logic [31:0] a, input logic [31:0] d);
    dma_req = 1'b1; dma_wr = wr; dma_addr = a; dma_wdata = d;
    wait_ack(1'b1, "dma_ack_wait");
    #1;
    dma_req = 1'b0; dma_wr = $urandom_range(0, 1); dma_addr = $urandom; dma_wdata = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_ref[i] = 32'hC0DE_0000 ^ (32'h0101_0101 * i);
      mem_dev[i] = mem_ref[i];
    end
    idle_cycles(3);
    reset = 1'b1;

    cpu_txn(1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    idle_cycles(1);
    cpu_txn(1'b1, 32'h0000_0080, 32'h1234_5678);
    cpu_txn(1'b0, 32'h0000_0080, 32'h0);
    idle_cycles(2);
    dma_txn(1'b0, 32'h0000_0040, 32'h0);

    // Both request together: CPU wins, DMA goes in the CPU ack cycle.
    fork
      cpu_txn(1'b1, 32'h0000_0010, 32'hA5A5_0001);
      dma_txn(1'b1, 32'h0000_0014, 32'h5A5A_0002);
    join
    fork
      begin
        for (int k = 0; k < 4; k++) cpu_txn(1'b1, 32'h20 + 32'(k * 4), $urandom);
      end
      dma_txn(1'b1, 32'h0000_0030, 32'hFEED_F00D);
    join
    cpu_txn(1'b0, 32'h0000_0030, 32'h0);

    fork
      begin
        for (int i = 0; i < 60; i++) begin
          idle_cycles($urandom_range(0, 2));
          cpu_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom);
        end
      end
      begin
        for (int j = 0; j < 60; j++) begin
          idle_cycles($urandom_range(0, 3));
          dma_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom);
        end
      end
    join

    // Asynchronous reset while a CPU read is in its latency window.
    idle_cycles(2);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_0100; cpu_wdata = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrd_mem_en", 64'(mem_en), 64'(0));
    check("midrd_cpu_ack", 64'(cpu_ack), 64'(0));
    check("midrd_cpu_rdata", 64'(cpu_rdata), 64'(0));
    idle_cycles(2);
    reset = 1'b1;
    wait_ack(1'b0, "midrd_resume_ack");
    #1;
    cpu_req = 1'b0;
    idle_cycles(4);

    check("cpu_queue_drained", 64'(cq.size()), 64'(0));
    check("dma_queue_drained", 64'(dq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
